// File: rtl/keypad_scanner_pkg.sv
// Shared constants for the keypad scanner: FSM states, default timing and key code mapping.
package keypad_scanner_pkg;

    localparam int unsigned ScanPeriodDefault = 25000;
    localparam int unsigned DebounceNDefault  = 4;

    typedef enum logic [1:0] {
        StScan     = 2'd0,
        StDebounce = 2'd1,
        StHeld     = 2'd2,
        StRelease  = 2'd3
    } kp_state_e;

    // Key code is the row in the upper two bits and the column in the lower two.
    function automatic logic [3:0] key_code_f(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

    // True when exactly one column line is pulled low.
    function automatic logic one_low_f(input logic [3:0] pat);
        int unsigned zeros;
        zeros = 0;
        for (int i = 0; i < 4; i++) begin
            if (!pat[i]) zeros++;
        end
        return zeros == 1;
    endfunction

    // Index of the lowest low column bit (only meaningful for a single low bit).
    function automatic logic [1:0] low_index_f(input logic [3:0] pat);
        logic [1:0] idx;
        idx = '0;
        for (int i = 3; i >= 0; i--) begin
            if (!pat[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_scan_tick.sv
// Row slot timer: counts 0..SCAN_PERIOD-1 and flags the last cycle of each slot.
module scan_tick #(
    parameter int unsigned SCAN_PERIOD = 25000
) (
    input  logic clk,
    input  logic rstn,
    output logic tick_o
);

    localparam int unsigned CntW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(SCAN_PERIOD - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Tick on the final count of the slot, then wrap to zero.
    always_comb begin
        tick_o = (cnt_q == CntMax);
        cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
    end

    // Slot counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with per-slot sampling, debounce and a four-digit entry register.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int unsigned SCAN_PERIOD = ScanPeriodDefault,
    parameter int unsigned DEBOUNCE_N  = DebounceNDefault
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  col_n_i,
    input  logic        clr_i,
    output logic [3:0]  row_n_o,
    output logic        key_valid_o,
    output logic [3:0]  key_code_o,
    output logic        key_held_o,
    output logic [15:0] data_o
);

    localparam int unsigned DbW = (DEBOUNCE_N > 1) ? $clog2(DEBOUNCE_N + 1) : 1;
    localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_N);
    localparam logic [DbW-1:0] DbOne = DbW'(1);

    logic [3:0]     col_meta_q, col_s_q;
    kp_state_e      state_q, state_d;
    logic [1:0]     row_q, row_d;
    logic [3:0]     pat_q, pat_d;
    logic [DbW-1:0] db_cnt_q, db_cnt_d;
    logic           key_valid_q, key_valid_d;
    logic           key_held_q, key_held_d;
    logic [3:0]     key_code_q, key_code_d;
    logic [15:0]    data_q, data_d;

    logic           tick;
    logic           col_idle;
    logic [DbW-1:0] db_inc;

    scan_tick #(
        .SCAN_PERIOD(SCAN_PERIOD)
    ) u_scan_tick (
        .clk    (clk),
        .rstn   (rstn),
        .tick_o (tick)
    );

    // Two-flop synchronizer for the asynchronous column lines; idle level is all-high.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            col_meta_q <= 4'hF;
            col_s_q    <= 4'hF;
        end else begin
            col_meta_q <= col_n_i;
            col_s_q    <= col_meta_q;
        end
    end

    assign col_idle = (col_s_q == 4'hF);
    // Stable-sample count saturates so a held multi-key press cannot wrap it.
    assign db_inc   = (db_cnt_q >= DbMax) ? DbMax : db_cnt_q + 1'b1;

    // Scan/debounce/hold/release next-state logic; all decisions happen on the slot tick.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        pat_d       = pat_q;
        db_cnt_d    = db_cnt_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        key_code_d  = key_code_q;
        unique case (state_q)
            StScan: begin
                if (tick) begin
                    if (col_idle) begin
                        row_d = row_q + 2'd1;
                    end else begin
                        pat_d    = col_s_q;
                        db_cnt_d = DbOne;
                        state_d  = StDebounce;
                    end
                end
            end
            StDebounce: begin
                if (tick) begin
                    if (col_idle) begin
                        row_d    = row_q + 2'd1;
                        db_cnt_d = '0;
                        state_d  = StScan;
                    end else if (col_s_q == pat_q) begin
                        db_cnt_d = db_inc;
                        // Multi-key patterns never accept; they just sit here until released.
                        if (db_inc >= DbMax && one_low_f(pat_q)) begin
                            key_code_d  = key_code_f(row_q, low_index_f(pat_q));
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            state_d     = StHeld;
                        end
                    end else begin
                        pat_d    = col_s_q;
                        db_cnt_d = DbOne;
                    end
                end
            end
            StHeld: begin
                if (tick && col_idle) begin
                    db_cnt_d = DbOne;
                    state_d  = StRelease;
                end
            end
            StRelease: begin
                if (tick) begin
                    if (col_idle) begin
                        db_cnt_d = db_inc;
                        if (db_inc >= DbMax) begin
                            key_held_d = 1'b0;
                            row_d      = row_q + 2'd1;
                            db_cnt_d   = '0;
                            state_d    = StScan;
                        end
                    end else begin
                        state_d = StHeld;
                    end
                end
            end
            default: begin
                state_d = StScan;
            end
        endcase
    end

    // Entry register shifts in the reported code the cycle after the pulse; clear wins.
    always_comb begin
        data_d = data_q;
        if (clr_i) begin
            data_d = '0;
        end else if (key_valid_q) begin
            data_d = {data_q[11:0], key_code_q};
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= StScan;
            row_q       <= '0;
            pat_q       <= 4'hF;
            db_cnt_q    <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            key_code_q  <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            pat_q       <= pat_d;
            db_cnt_q    <= db_cnt_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            key_code_q  <= key_code_d;
            data_q      <= data_d;
        end
    end

    assign row_n_o     = ~(4'b0001 << row_q);
    assign key_valid_o = key_valid_q;
    assign key_code_o  = key_code_q;
    assign key_held_o  = key_held_q;
    assign data_o      = data_q;

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_PERIOD, default 25000: clk cycles per row slot; one sample tick at the end of each slot.
REQ-002 Parameter DEBOUNCE_N, default 4: consecutive identical samples required to accept a press or release.
REQ-003 clk  input  1  system clock.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 col_n  input  4  keypad columns, active-low, externally pulled up, asynchronous to clk.
REQ-006 clr  input  1  synchronous clear of the entry register data.
REQ-007 row_n  output  4  keypad row drive, active-low one-hot.
REQ-008 key_valid  output  1  one-cycle pulse per accepted key press.
REQ-009 key_code  output  4  hex code of the last accepted key, held until the next press.
REQ-010 key_held  output  1  high while an accepted key is still pressed.
REQ-011 data  output  16  last four accepted codes, newest in [3:0]; directly feeds the 16-bit data input of the display driver.

Function
REQ-012 col_n SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value colS.
REQ-013 Slot counter counts 0..SCAN_PERIOD-1 and wraps; tick is true in the cycle where counter+1 == SCAN_PERIOD.
REQ-014 row_n SHALL equal ~(4'b0001 << row); row is 2 bits and wraps 3 -> 0.
REQ-015 FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
REQ-016 SCAN: on tick with colS == 4'hF, row increments. On tick with colS != 4'hF, row freezes, pattern is latched, stable count = 1, and the FSM goes to DEBOUNCE.
REQ-017 DEBOUNCE: on each tick, if colS equals the latched pattern, count increments; otherwise pattern is relatched and count = 1. If colS == 4'hF on the tick, the FSM returns to SCAN and row increments.
REQ-018 DEBOUNCE: when count reaches DEBOUNCE_N and the pattern has exactly one low bit, key_code = {row, col index} (row*4+col), key_valid pulses, key_held = 1, and the FSM goes to HELD. With multiple low bits the press is ignored, the FSM stays in DEBOUNCE, and no pulse is emitted.
REQ-019 key_valid SHALL be high for exactly the one cycle after the accepting tick, once per physical press, with no auto-repeat.
REQ-020 HELD: row stays frozen. On a tick with colS == 4'hF the FSM goes to RELEASE with count = 1. Other column changes while held are ignored.
REQ-021 RELEASE: each tick with colS == 4'hF increments count; any tick with colS != 4'hF returns the FSM to HELD. At count == DEBOUNCE_N, key_held = 0, row increments, and the FSM goes to SCAN.
REQ-022 On key_valid, data <= {data[11:0], key_code}.
REQ-023 clr SHALL zero data in the next cycle; if clr and a key_valid update coincide, clr wins and the key is still reported on key_code/key_valid.
REQ-024 All outputs SHALL be registered; no combinational path from col_n to any output.

Reset
REQ-025 While rstn == 0 at a clk edge: state = SCAN, counter = 0, row = 0, row_n = 4'b1110, synchronizer = 4'hF, count = 0, key_valid = 0, key_held = 0, key_code = 0, data = 0.
REQ-026 A reset asserted mid-debounce or mid-hold SHALL abort the press without emitting key_valid; after release of reset, scanning restarts at row 0.

Structure
REQ-027 State encodings, default SCAN_PERIOD/DEBOUNCE_N and the key_code mapping SHALL live in a shared constants header used by the bench.
REQ-028 One sub-module, scan_tick, SHALL implement the slot counter and the tick output; the FSM and datapath stay in keypad_scanner.

Verification (SCAN_PERIOD=4, DEBOUNCE_N=3)
REQ-029 Reset: after release, row_n = 1110 and rotates 1101, 1011, 0111, 1110 every 4 cycles; key_valid = 0 and data = 0.
REQ-030 Clean press, row 2 / col 1 held 40 cycles: exactly one key_valid pulse; key_code = 4'h9; data = 16'h0009; key_held falls 3 ticks after release.
REQ-031 Bounce: col toggles on alternate ticks for 5 ticks, then stable: no key_valid until 3 consecutive stable ticks, then exactly one pulse.
REQ-032 Two-key press, cols 0 and 3 low on one row: no key_valid; scanning resumes after release.
REQ-033 Entry sequence 1, 2, 3, 4, 5 (each pressed and released): data = 16'h2345. Asserting clr in the same cycle as the pulse for key 6 gives data = 0 and key_code = 6.
REQ-034 rstn asserted while in HELD: key_held = 0 next cycle, with no key_valid pulse.
